adder4_registered: RTL and testbench

//   4-bit binary adder with carry-in and carry-out, built as an explicit ripple-carry chain of full-adder cells.

---
 rtl/adder4_registered_if.sv | 49 ++++
 rtl/adder4_registered.sv | 63 ++++++
 tb/tb_adder4_registered.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/adder4_registered_if.sv
// ----------------------------------------------------------------------------
// adder4_registered_if
//   Operand/result bundle for the registered ripple-carry adder.
//
//   Signals (WIDTH defaults to 4):
//     x      operand A, unsigned                    (master -> slave)
//     y      operand B, unsigned                    (master -> slave)
//     c_in   carry into bit 0                       (master -> slave)
//     sum    registered sum, (x+y+c_in) mod 2^WIDTH (slave -> master)
//     c_out  registered carry out of the MSB        (slave -> master)
//     ovf    registered two's-complement overflow   (slave -> master)
//
//   Modports:
//     master  drives the operands and observes the results (bench / upstream)
//     slave   the adder: samples the operands and drives the results
//
//   Transfer semantics: there is no valid/ready handshake. The master holds
//   x, y and c_in stable around every rising clk edge, and the slave takes a
//   new operand set on every edge. The result of the operands present at edge
//   N is visible after edge N and holds until edge N+1.
// ----------------------------------------------------------------------------
interface adder4_registered_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output x,
        output y,
        output c_in,
        input  sum,
        input  c_out,
        input  ovf
    );

    modport slave (
        input  x,
        input  y,
        input  c_in,
        output sum,
        output c_out,
        output ovf
    );
endinterface

// File: rtl/adder4_registered.sv
// ----------------------------------------------------------------------------
// adder4_registered
//   WIDTH-bit binary adder with carry-in and carry-out, built as an explicit
//   ripple chain of full-adder cells, followed by a single register stage.
//   One clock of latency; outputs are glitch-free because they come straight
//   from flops.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset; clears sum, c_out, ovf
//     bus    slave modport of adder4_registered_if
//              x, y, c_in  in   operands and carry-in
//              sum         out  registered (x+y+c_in) mod 2^WIDTH
//              c_out       out  registered carry out of the MSB
//              ovf         out  registered carry-into-MSB ^ carry-out-of-MSB
// ----------------------------------------------------------------------------
module adder4_registered #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adder4_registered_if.slave  bus
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    // Ripple-carry chain of full-adder cells, no lookahead.
    always_comb begin
        carry    = '0;
        sum_comb = '0;
        carry[0] = bus.c_in;
        for (int i = 0; i < WIDTH; i++) begin
            sum_comb[i]  = bus.x[i] ^ bus.y[i] ^ carry[i];
            carry[i + 1] = (bus.x[i] & bus.y[i]) | (carry[i] & (bus.x[i] ^ bus.y[i]));
        end
    end

    // Result register. Reset clears immediately, so an in-flight result is
    // discarded and nothing stale can reappear after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_comb;
            c_out_q <= carry[WIDTH];
            // Signed overflow: carry into the sign bit disagrees with carry out.
            ovf_q   <= carry[WIDTH] ^ carry[WIDTH - 1];
        end
    end

    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_adder4_registered.sv
module tb_adder4_registered;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    adder4_registered_if #(.WIDTH(4)) bus ();

    adder4_registered #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Driver: change inputs on the falling edge, one vector per cycle.
    // ------------------------------------------------------------------
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(negedge clk);
        bus.x    = a;
        bus.y    = b;
        bus.c_in = ci;
    endtask

    // Drive a vector, clock it in, sample #1 after the rising edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci);
        drive(a, b, ci);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        bus.x    = 4'hA;
        bus.y    = 4'h5;
        bus.c_in = 1'b1;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Asynchronous clear, before any clock edge has occurred.
        tests_run++;
        if ({bus.c_out, bus.sum, bus.ovf} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got c_out=%b sum=%h ovf=%b, want 0/0/0",
                     bus.c_out, bus.sum, bus.ovf);
        end
        // Stays zero through clock edges while held in reset.
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.c_out, bus.sum, bus.ovf} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_held: got c_out=%b sum=%h ovf=%b, want 0/0/0",
                     bus.c_out, bus.sum, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exhaustive;
        logic [4:0] exp_total;
        logic       exp_ovf;
        int         errs;
        errs = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                apply(a[3:0], b[3:0], 1'b0);
                exp_total = 5'(a + b);
                // Same-sign operands whose sum has the other sign overflow.
                exp_ovf = (a[3] == b[3]) && (exp_total[3] != a[3]);
                tests_run++;
                if ({bus.c_out, bus.sum} !== exp_total || bus.ovf !== exp_ovf) begin
                    tests_failed++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL exhaustive x=%h y=%h: got {c_out,sum}=%h ovf=%b, want %h ovf=%b",
                                 a[3:0], b[3:0], {bus.c_out, bus.sum}, bus.ovf, exp_total, exp_ovf);
                end
            end
        end
    endtask

    task automatic test_corners;
        // x, y, c_in, expected {c_out,sum}, expected ovf (hand-computed)
        logic [3:0] vx   [9] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h8, 4'h0, 4'h5, 4'h3};
        logic [3:0] vy   [9] = '{4'hF, 4'hF, 4'h1, 4'h0, 4'h1, 4'h8, 4'h0, 4'h2, 4'hC};
        logic       vc   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0] vexp [9] = '{5'h1E, 5'h1F, 5'h10, 5'h10, 5'h08, 5'h10, 5'h00, 5'h08, 5'h10};
        logic       vovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            apply(vx[i], vy[i], vc[i]);
            tests_run++;
            if ({bus.c_out, bus.sum} !== vexp[i] || bus.ovf !== vovf[i]) begin
                tests_failed++;
                $display("FAIL corner%0d x=%h y=%h c_in=%b: got {c_out,sum}=%h ovf=%b, want %h ovf=%b",
                         i, vx[i], vy[i], vc[i], {bus.c_out, bus.sum}, bus.ovf, vexp[i], vovf[i]);
            end
        end
    endtask

    task automatic test_no_comb_path;
        apply(4'h6, 4'h3, 1'b0);   // 0x09, ovf=1 (6+3 = 9 > 7)
        // Change inputs mid-cycle; registered outputs must not follow.
        bus.x    = 4'hF;
        bus.y    = 4'hF;
        bus.c_in = 1'b1;
        #2;
        tests_run++;
        if ({bus.c_out, bus.sum} !== 5'h09 || bus.ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_between_edges: got {c_out,sum}=%h ovf=%b, want 09 ovf=1",
                     {bus.c_out, bus.sum}, bus.ovf);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus.c_out, bus.sum} !== 5'h1F || bus.ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL next_edge_load: got {c_out,sum}=%h ovf=%b, want 1F ovf=0",
                     {bus.c_out, bus.sum}, bus.ovf);
        end
    endtask

    task automatic test_reset_midstream;
        apply(4'hA, 4'h7, 1'b0);   // 0x11, ovf=0
        tests_run++;
        if ({bus.c_out, bus.sum} !== 5'h11 || bus.ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset_load: got {c_out,sum}=%h ovf=%b, want 11 ovf=0",
                     {bus.c_out, bus.sum}, bus.ovf);
        end
        // Assert reset between edges.
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.c_out, bus.sum, bus.ovf} !== 6'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_clear: got c_out=%b sum=%h ovf=%b, want 0/0/0",
                     bus.c_out, bus.sum, bus.ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.c_out, bus.sum, bus.ovf} !== 6'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_held: got c_out=%b sum=%h ovf=%b, want 0/0/0",
                     bus.c_out, bus.sum, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({bus.c_out, bus.sum, bus.ovf} !== 6'b0) begin
            tests_failed++;
            $display("FAIL release_no_stale: got c_out=%b sum=%h ovf=%b, want 0/0/0",
                     bus.c_out, bus.sum, bus.ovf);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus.c_out, bus.sum} !== 5'h11 || bus.ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_reload: got {c_out,sum}=%h ovf=%b, want 11 ovf=0",
                     {bus.c_out, bus.sum}, bus.ovf);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_exhaustive();
        test_corners();
        test_no_comb_path();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
